// File: rtl/fp32_pkg.sv
// Shared binary32 definitions for the floating-point add, compare and divide units.
// Field widths, special encodings, debug-word bit positions and unpack helpers.
package fp32_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;
    localparam logic [31:0] NEG_INF = 32'hFF80_0000;

    localparam int DBG_EFF_SUB = 8;
    localparam int DBG_SWAP    = 9;
    localparam int DBG_OVF     = 10;
    localparam int DBG_UNF     = 11;
    localparam int DBG_INV     = 12;
    localparam int DBG_INEXACT = 13;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] frac;
    } fp32_t;

    // Denormals become a zero of the same sign; everything else passes through.
    function automatic fp32_t flush_denormal(input logic [31:0] x);
        fp32_t f;
        f = fp32_t'(x);
        if (f.exp == '0) f.frac = '0;
        return f;
    endfunction

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != '0);
    endfunction

    function automatic logic is_inf(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] == '0);
    endfunction

endpackage

// File: rtl/fp32_normalize_round.sv
// Normalizes a 28-bit mantissa (carry, hidden, 23 fraction, G/R/S), rounds to
// nearest-even, and packs a binary32 with overflow / flush-to-zero handling.
module fp32_normalize_round
    import fp32_pkg::*;
(
    input  logic               sign_i,
    input  logic signed [9:0]  exp_i,
    input  logic [27:0]        mant_i,
    output logic [31:0]        result_o,
    output logic               overflow_o,
    output logic               underflow_o,
    output logic               inexact_o
);

    logic [4:0]         lzc;
    logic [26:0]        norm;
    logic signed [9:0]  norm_exp;
    logic               round_up;
    logic [24:0]        rounded;
    logic signed [9:0]  final_exp;
    logic [22:0]        frac;

    always_comb begin
        lzc = 5'd0;
        for (int i = 0; i < 27; i++) begin
            if (mant_i[i]) lzc = 5'(26 - i);
        end
    end

    always_comb begin
        if (mant_i[27]) begin
            norm     = {mant_i[27:2], mant_i[1] | mant_i[0]};
            norm_exp = exp_i + 10'sd1;
        end else begin
            norm     = mant_i[26:0] << lzc;
            norm_exp = exp_i - signed'({5'd0, lzc});
        end

        round_up  = norm[2] & (norm[1] | norm[0] | norm[3]);
        rounded   = {1'b0, norm[26:3]} + {24'd0, round_up};
        final_exp = norm_exp + (rounded[24] ? 10'sd1 : 10'sd0);
        frac      = rounded[24] ? rounded[23:1] : rounded[22:0];

        result_o    = '0;
        overflow_o  = 1'b0;
        underflow_o = 1'b0;
        inexact_o   = 1'b0;
        // Exact cancellation yields +0 with no flags.
        if (mant_i != '0) begin
            if (final_exp >= 10'sd255) begin
                result_o   = {sign_i, 8'hFF, 23'd0};
                overflow_o = 1'b1;
                inexact_o  = 1'b1;
            end else if (final_exp <= 10'sd0) begin
                underflow_o = 1'b1;
                inexact_o   = 1'b1;
            end else begin
                result_o  = {sign_i, final_exp[7:0], frac};
                inexact_o = |norm[2:0];
            end
        end
    end

endmodule

// File: rtl/floating_add.sv
// Combinational binary32 adder/subtractor with an enable-gated hold register
// for the result and a status word describing the last operation.
module floating_add
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        subtract,
    input  logic        enable,
    output logic [31:0] result,
    output logic [31:0] debug
);

    fp32_t              fa, fb, big;
    logic [7:0]         s_exp;
    logic [22:0]        s_frac;
    logic               nan_in, inf_a, inf_b;
    logic               swap, eff_sub;
    logic [7:0]         exp_diff;
    logic [49:0]        shifted;
    logic [26:0]        aligned;
    logic [27:0]        sum;
    logic [31:0]        nr_result;
    logic               nr_ovf, nr_unf, nr_inexact;
    logic [31:0]        result_d, result_q;
    logic [31:0]        debug_d, debug_q;
    logic               ovf, unf, invalid, inexact;

    always_comb begin
        fa      = flush_denormal(a);
        fb      = flush_denormal(b);
        fb.sign = fb.sign ^ subtract;
        nan_in  = is_nan(a) | is_nan(b);
        inf_a   = is_inf(a);
        inf_b   = is_inf(b);

        swap    = {fb.exp, fb.frac} > {fa.exp, fa.frac};
        big     = swap ? fb : fa;
        s_exp   = swap ? fa.exp : fb.exp;
        s_frac  = swap ? fa.frac : fb.frac;
        eff_sub = fa.sign ^ fb.sign;
        // Both exponents fit in 8 bits, so the difference never exceeds 255.
        exp_diff = big.exp - s_exp;

        shifted = {1'b1, s_frac, 26'd0} >> exp_diff;
        if (exp_diff >= 8'd26) aligned = 27'd1;
        else                   aligned = {shifted[49:24], shifted[23] | (|shifted[22:0])};

        if (eff_sub) sum = {1'b0, 1'b1, big.frac, 3'b000} - {1'b0, aligned};
        else         sum = {1'b0, 1'b1, big.frac, 3'b000} + {1'b0, aligned};
    end

    fp32_normalize_round u_norm (
        .sign_i      (big.sign),
        .exp_i       (signed'({2'b00, big.exp})),
        .mant_i      (sum),
        .result_o    (nr_result),
        .overflow_o  (nr_ovf),
        .underflow_o (nr_unf),
        .inexact_o   (nr_inexact)
    );

    always_comb begin
        result_d = nr_result;
        ovf      = nr_ovf;
        unf      = nr_unf;
        inexact  = nr_inexact;
        invalid  = 1'b0;
        if (nan_in || (inf_a && inf_b && eff_sub)) begin
            result_d = QNAN;
            invalid  = 1'b1;
            ovf      = 1'b0;
            unf      = 1'b0;
            inexact  = 1'b0;
        end else if (inf_a || inf_b || s_exp == 8'd0) begin
            // Infinity dominates, a zero smaller operand leaves the larger one exact.
            result_d = big;
            if (big.exp == 8'd0) result_d = {fa.sign & fb.sign, 31'd0};
            ovf      = 1'b0;
            unf      = 1'b0;
            inexact  = 1'b0;
        end
        debug_d = {18'd0, inexact, invalid, unf, ovf, swap, eff_sub, exp_diff};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_q <= '0;
            debug_q  <= '0;
        end else if (enable) begin
            result_q <= result_d;
            debug_q  <= debug_d;
        end
    end

    assign result = !reset ? 32'd0 : (enable ? result_d : result_q);
    assign debug  = !reset ? 32'd0 : (enable ? debug_d  : debug_q);

endmodule

// File: tb/tb_floating_add.sv
// Directed-vector bench for floating_add: arithmetic, rounding, specials, hold and reset.
module tb_floating_add;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a, b;
    logic        subtract, enable;
    logic [31:0] result, debug;
    int          checks = 0;
    int          errors = 0;

    floating_add dut (
        .clk      (clk),
        .reset    (reset),
        .a        (a),
        .b        (b),
        .subtract (subtract),
        .enable   (enable),
        .result   (result),
        .debug    (debug)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [31:0] ta, input logic [31:0] tb, input logic ts, input logic te);
        @(negedge clk);
        a = ta; b = tb; subtract = ts; enable = te;
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b0; a = 32'h3F80_0000; b = 32'h4000_0000; subtract = 1'b0; enable = 1'b1;
        #3;
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=%h", result, 32'h0); end
        checks++; if (debug !== 32'h0) begin errors++; $display("FAIL reset_debug got=%h exp=%h", debug, 32'h0); end
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic test_add_sub();
        drive(32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b1);
        checks++; if (result !== 32'h4040_0000) begin errors++; $display("FAIL add_1_2 got=%h exp=%h", result, 32'h4040_0000); end
        checks++; if (debug !== 32'h0000_0201) begin errors++; $display("FAIL add_1_2_debug got=%h exp=%h", debug, 32'h0000_0201); end
        drive(32'h4040_0000, 32'h3F80_0000, 1'b1, 1'b1);
        checks++; if (result !== 32'h4000_0000) begin errors++; $display("FAIL sub_3_1 got=%h exp=%h", result, 32'h4000_0000); end
        checks++; if (debug !== 32'h0000_0101) begin errors++; $display("FAIL sub_3_1_debug got=%h exp=%h", debug, 32'h0000_0101); end
        drive(32'h3F80_0000, 32'hBF80_0000, 1'b0, 1'b1);
        checks++; if (result !== 32'h0000_0000) begin errors++; $display("FAIL cancel got=%h exp=%h", result, 32'h0); end
    endtask

    task automatic test_rounding();
        drive(32'h3F80_0000, 32'h3380_0000, 1'b0, 1'b1);
        checks++; if (result !== 32'h3F80_0000) begin errors++; $display("FAIL round_tie got=%h exp=%h", result, 32'h3F80_0000); end
        checks++; if (debug !== 32'h0000_2018) begin errors++; $display("FAIL round_tie_debug got=%h exp=%h", debug, 32'h0000_2018); end
        drive(32'h3F80_0000, 32'h33C0_0000, 1'b0, 1'b1);
        checks++; if (result !== 32'h3F80_0001) begin errors++; $display("FAIL round_up got=%h exp=%h", result, 32'h3F80_0001); end
        checks++; if (debug[13] !== 1'b1) begin errors++; $display("FAIL round_up_inexact got=%b exp=1", debug[13]); end
    endtask

    task automatic test_overflow_invalid();
        drive(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 1'b1);
        checks++; if (result !== 32'h7F80_0000) begin errors++; $display("FAIL overflow got=%h exp=%h", result, 32'h7F80_0000); end
        checks++; if (debug[10] !== 1'b1) begin errors++; $display("FAIL overflow_flag got=%b exp=1", debug[10]); end
        drive(32'h7F80_0000, 32'h7F80_0000, 1'b1, 1'b1);
        checks++; if (result !== 32'h7FC0_0000) begin errors++; $display("FAIL inf_minus_inf got=%h exp=%h", result, 32'h7FC0_0000); end
        checks++; if (debug[12] !== 1'b1) begin errors++; $display("FAIL invalid_flag got=%b exp=1", debug[12]); end
    endtask

    task automatic test_specials();
        drive(32'h7FA0_0001, 32'h3F80_0000, 1'b0, 1'b1);
        checks++; if (result !== 32'h7FC0_0000) begin errors++; $display("FAIL nan_in got=%h exp=%h", result, 32'h7FC0_0000); end
        drive(32'hFF80_0000, 32'h3F80_0000, 1'b0, 1'b1);
        checks++; if (result !== 32'hFF80_0000) begin errors++; $display("FAIL inf_plus_finite got=%h exp=%h", result, 32'hFF80_0000); end
        drive(32'h7F80_0000, 32'h7F80_0000, 1'b0, 1'b1);
        checks++; if (result !== 32'h7F80_0000) begin errors++; $display("FAIL inf_plus_inf got=%h exp=%h", result, 32'h7F80_0000); end
        drive(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
        checks++; if (result !== 32'h8000_0000) begin errors++; $display("FAIL negzero_sum got=%h exp=%h", result, 32'h8000_0000); end
        drive(32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1);
        checks++; if (result !== 32'h0000_0000) begin errors++; $display("FAIL mixed_zero_sum got=%h exp=%h", result, 32'h0); end
    endtask

    task automatic test_denormal();
        drive(32'h0000_0001, 32'h3F80_0000, 1'b0, 1'b1);
        checks++; if (result !== 32'h3F80_0000) begin errors++; $display("FAIL denorm_in got=%h exp=%h", result, 32'h3F80_0000); end
        drive(32'h0080_0000, 32'h0080_0001, 1'b1, 1'b1);
        checks++; if (result !== 32'h0000_0000) begin errors++; $display("FAIL underflow got=%h exp=%h", result, 32'h0); end
        checks++; if (debug[11] !== 1'b1) begin errors++; $display("FAIL underflow_flag got=%b exp=1", debug[11]); end
    endtask

    task automatic test_back_to_back();
        drive(32'h4000_0000, 32'h4000_0000, 1'b0, 1'b1);
        checks++; if (result !== 32'h4080_0000) begin errors++; $display("FAIL b2b_2_2 got=%h exp=%h", result, 32'h4080_0000); end
        drive(32'h4080_0000, 32'h3F80_0000, 1'b1, 1'b1);
        checks++; if (result !== 32'h4040_0000) begin errors++; $display("FAIL b2b_4_1 got=%h exp=%h", result, 32'h4040_0000); end
        drive(32'h4120_0000, 32'h4120_0000, 1'b0, 1'b1);
        checks++; if (result !== 32'h41A0_0000) begin errors++; $display("FAIL b2b_10_10 got=%h exp=%h", result, 32'h41A0_0000); end
    endtask

    task automatic test_hold();
        drive(32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b1);
        drive(32'h4120_0000, 32'h4000_0000, 1'b0, 1'b0);
        checks++; if (result !== 32'h4040_0000) begin errors++; $display("FAIL hold_result got=%h exp=%h", result, 32'h4040_0000); end
        checks++; if (debug !== 32'h0000_0201) begin errors++; $display("FAIL hold_debug got=%h exp=%h", debug, 32'h0000_0201); end
        drive(32'h4120_0000, 32'h3F80_0000, 1'b1, 1'b0);
        checks++; if (result !== 32'h4040_0000) begin errors++; $display("FAIL hold_next_edge got=%h exp=%h", result, 32'h4040_0000); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); #1;
        reset = 1'b0;
        #1;
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_mid got=%h exp=%h", result, 32'h0); end
        @(negedge clk); reset = 1'b1;
        #2;
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_cleared_hold got=%h exp=%h", result, 32'h0); end
        checks++; if (debug !== 32'h0) begin errors++; $display("FAIL reset_cleared_debug got=%h exp=%h", debug, 32'h0); end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_rounding();
        test_overflow_invalid();
        test_specials();
        test_denormal();
        test_back_to_back();
        test_hold();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
